// File: rtl/fetch_pkg.sv
// Shared widths, constants and state type for the instruction fetch stage.
package fetch_pkg;
    localparam int          ADDR_W    = 64;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or flush to a NOP bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = ADDR_W,
    parameter int IW   = INSTR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_pc,
    input  logic [IW-1:0]   i_instr,
    output logic            o_valid,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus4,
    output logic [IW-1:0]   o_instr
);
    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pc_plus4;
    logic [IW-1:0]   r_instr;

    // Flush keeps the pc fields so the bubble still carries the last fetched PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= PC_W'(64'd4);
            r_instr    <= IW'(NOP_INSTR);
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= IW'(NOP_INSTR);
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + PC_W'(64'd4);
            r_instr    <= i_instr;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;
endmodule

// File: rtl/instruction_fetch_unit.sv
// RV64 fetch stage: PC register, instruction memory address port, IF/ID capture.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets into a sticky FAULT state.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        fetch_count,
    output logic               misalign_fault
);
    import fetch_pkg::*;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_fetch_count;
    logic [ADDR_W-1:0] w_target;
    logic              w_load;
    logic              w_flush;

    assign w_target = {redirect_target[ADDR_W-1:2], 2'b00};
    assign w_load   = (r_state == RUN) && !redirect_valid && !stall;
    assign w_flush  = (r_state == FAULT) || redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_misalign;
    assign w_misalign     = (redirect_target[1:0] != 2'b00);
    assign misalign_fault = r_fault;
`else
    logic w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = ^redirect_target[1:0];
    assign misalign_fault   = 1'b0;
`endif

    // PC, fetch counter and fetch state; redirect outranks stall, FAULT freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_state       <= RUN;
            r_fetch_count <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault       <= 1'b0;
`endif
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                            r_pc    <= redirect_target;
                        end else begin
                            r_pc <= w_target;
                        end
`else
                        r_pc <= w_target;
`endif
                    end else if (!stall) begin
                        r_pc          <= r_pc + ADDR_W'(64'd4);
                        r_fetch_count <= r_fetch_count + 32'd1;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W (ADDR_W),
        .IW   (INSTR_W)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_pc       (r_pc),
        .i_instr    (imem_instr),
        .o_valid    (ifid_valid),
        .o_pc       (ifid_pc),
        .o_pc_plus4 (ifid_pc_plus4),
        .o_instr    (ifid_instr)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit against a program-counter level reference model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic [31:0] fetch_count;
    logic        misalign_fault;

    logic [63:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        ifid_valid2;
    logic [63:0] ifid_pc2;
    logic [63:0] ifid_pc_plus4_2;
    logic [31:0] ifid_instr2;
    logic [31:0] fetch_count2;
    logic        misalign_fault2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'd0:   mem_word = 32'h0000_0033;
            64'd4:   mem_word = 32'h00A5_0533;
            64'd8:   mem_word = 32'h4005_8533;
            64'd12:  mem_word = 32'h0000_0000;
            default: mem_word = {a[31:2], 2'b11} ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem_instr2 = mem_word(imem_addr2);

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .fetch_count(fetch_count), .misalign_fault(misalign_fault)
    );

    instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_top_pc (
        .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_target(64'd0),
        .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus4_2),
        .ifid_instr(ifid_instr2), .fetch_count(fetch_count2), .misalign_fault(misalign_fault2)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_fault;
    logic [63:0] m_last_pc;
    logic [31:0] m_last_instr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'd0; m_valid = 1'b0; m_count = 32'd0; m_fault = 1'b0;
        m_last_pc = 64'd0; m_last_instr = NOP;
        sb.delete();
    endtask

    task automatic model_edge(input logic s, input logic rv, input logic [63:0] t);
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
            m_last_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (t[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_pc = t;
            end else begin
                m_pc = t;
            end
`else
            m_pc = t & ~64'd3;
`endif
        end else if (!s) begin
            sb.push_back('{pc: m_pc, instr: mem_word(m_pc), cnt: m_count + 32'd1});
            m_last_pc = m_pc;
            m_last_instr = mem_word(m_pc);
            m_pc = m_pc + 64'd4;
            m_count = m_count + 32'd1;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_state();
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_valid});
        chk("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
        chk("ifid_pc", ifid_pc, m_last_pc);
        chk("ifid_pc_plus4", ifid_pc_plus4, m_last_pc + 64'd4);
        chk("ifid_instr", {32'd0, ifid_instr}, {32'd0, m_last_instr});
        chk("misalign_fault", {63'd0, misalign_fault}, {63'd0, m_fault});
    endtask

    // Called at a falling edge: check the present state, drive inputs, advance model to next edge.
    task automatic step(input logic s, input logic rv, input logic [63:0] t);
        check_state();
        stall = s;
        redirect_valid = rv;
        redirect_target = t;
        model_edge(s, rv, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: each newly loaded instruction is popped from the scoreboard and compared.
    initial begin
        logic [31:0] prev_cnt;
        exp_t        e;
        prev_cnt = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_cnt = 32'd0;
            end else if (ifid_valid && fetch_count != prev_cnt) begin
                prev_cnt = fetch_count;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", ifid_pc, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", ifid_pc, e.pc);
                    chk("sb_pc_plus4", ifid_pc_plus4, e.pc + 64'd4);
                    chk("sb_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
                    chk("sb_count", {32'd0, fetch_count}, {32'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        logic        s;
        logic        rv;
        logic [63:0] t;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_state();
        chk("top_pc_reset_addr", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        reset = 1'b0;

        // Free-running fetch from address 0; after the first edge check the wrap instance.
        step(1'b0, 1'b0, 64'd0);
        chk("wrap_imem_addr", imem_addr2, 64'd0);
        chk("wrap_pc_plus4", ifid_pc_plus4_2, 64'd0);
        chk("wrap_pc", ifid_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_valid", {63'd0, ifid_valid2}, 64'd1);
        step(1'b0, 1'b0, 64'd0);
        // Stall for three cycles while IF/ID shows pc 4, then release.
        repeat (3) step(1'b1, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        // Redirect to 0 while PC is 16 region, then redirect+stall, then back-to-back.
        step(1'b0, 1'b1, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b1, 1'b1, 64'h20);
        step(1'b0, 1'b1, 64'h100);
        step(1'b0, 1'b1, 64'h8);
        repeat (2) step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'h6);
        repeat (3) step(1'b0, 1'b0, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            s  = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 99) < 12);
            t  = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) t = t & ~64'd3;
            step(s, rv, t);
        end

        // Reset mid-operation with stall and redirect both asserted.
        check_state();
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h40;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_state();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        repeat (5) step(1'b0, 1'b0, 64'd0);

        // Drain: hold with stall so the monitor consumes the final entry.
        check_state();
        stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
